// File: rtl/stack_op_ctrl.sv
// Multicycle sequencer for MIPS PUSH/POP: drives datapath control lines cycle by
// cycle after the main control FSM hands off, then returns control with done.
module stack_op_ctrl #(
    parameter int          MEM_LATENCY = 2,
    parameter logic [2:0]  ALU_ADD     = 3'b001,
    parameter logic [2:0]  ALU_SUB     = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_pop,
    input  logic       alu_overflow,
    output logic [2:0] reg_dest_sel,
    output logic [1:0] mem_to_reg_sel,
    output logic       reg_write,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       alu_out_load,
    output logic [1:0] addr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mdr_load,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [3:0] {
        IDLE,
        PUSH_DEC,
        PUSH_WB_SP,
        PUSH_MEM,
        POP_RD,
        POP_WB_RT,
        POP_INC,
        POP_WB_SP,
        DONE,
        ERR
    } state_t;

    localparam int          CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter only advances while a memory access is held; any exit leaves it at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = is_pop ? POP_RD : PUSH_DEC;
                end
            end
            PUSH_DEC:   state_d = alu_overflow ? ERR : PUSH_WB_SP;
            PUSH_WB_SP: state_d = PUSH_MEM;
            PUSH_MEM: begin
                if (cnt_last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            POP_RD: begin
                if (cnt_last) begin
                    state_d = POP_WB_RT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            POP_WB_RT:  state_d = POP_INC;
            POP_INC:    state_d = alu_overflow ? ERR : POP_WB_SP;
            POP_WB_SP:  state_d = DONE;
            DONE:       state_d = IDLE;
            ERR:        state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        reg_dest_sel   = 3'b000;
        mem_to_reg_sel = 2'b00;
        reg_write      = 1'b0;
        alu_src_b      = 2'b00;
        alu_op         = 3'b000;
        alu_out_load   = 1'b0;
        addr_src       = 2'b00;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mdr_load       = 1'b0;
        busy           = (state_q != IDLE);
        done           = 1'b0;
        error          = 1'b0;
        case (state_q)
            PUSH_DEC: begin
                alu_op       = ALU_SUB;
                alu_src_b    = 2'b01;
                alu_out_load = 1'b1;
            end
            PUSH_WB_SP, POP_WB_SP: begin
                reg_dest_sel   = 3'b011;
                mem_to_reg_sel = 2'b00;
                reg_write      = 1'b1;
            end
            PUSH_MEM: begin
                mem_write = 1'b1;
                addr_src  = 2'b01;
            end
            POP_RD: begin
                mem_read = 1'b1;
                addr_src = 2'b10;
                mdr_load = cnt_last;
            end
            POP_WB_RT: begin
                reg_dest_sel   = 3'b000;
                mem_to_reg_sel = 2'b01;
                reg_write      = 1'b1;
            end
            POP_INC: begin
                alu_op       = ALU_ADD;
                alu_src_b    = 2'b01;
                alu_out_load = 1'b1;
            end
            DONE:    done  = 1'b1;
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

endmodule
